// File: rtl/printing_grid_engine_if.sv
// Load/control/result bundle for the printing grid engine.
// The master side feeds rows and starts runs; the slave side is the engine.
interface printing_grid_engine_if #(
  parameter int WIDTH = 140,
  parameter int CNT_W = 15
);
  logic             load_valid;
  logic [WIDTH-1:0] load_row;
  logic             load_ready;
  logic             start;
  logic             mode;
  logic             busy;
  logic             finished;
  logic [CNT_W-1:0] result;
  logic [7:0]       passes;

  modport master (
    output load_valid, load_row, start, mode,
    input  load_ready, busy, finished, result, passes
  );

  modport slave (
    input  load_valid, load_row, start, mode,
    output load_ready, busy, finished, result, passes
  );
endinterface

// File: rtl/printing_grid_engine.sv
// Printing grid engine: stores a HEIGHT x WIDTH occupancy grid and counts
// cells whose 8-neighbour occupancy is below THRESHOLD, either once (mode 0)
// or repeatedly removing those cells until nothing changes (mode 1).
// One grid row is evaluated per clock; all columns of a row in parallel.
module printing_grid_engine #(
  parameter int WIDTH     = 140,
  parameter int HEIGHT    = 140,
  parameter int THRESHOLD = 4,
  parameter int CNT_W     = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  printing_grid_engine_if.slave bus
);

  localparam int IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int RC_W  = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(HEIGHT - 1);
  // Neighbour counts never exceed 8, so larger thresholds behave like 9.
  localparam int THR_C = (THRESHOLD > 9) ? 9 : ((THRESHOLD < 0) ? 0 : THRESHOLD);

  typedef enum logic [1:0] {IDLE, PROCESS, DONE} state_t;

  state_t state_reg, state_next;

  logic [WIDTH-1:0] grid_mem [HEIGHT];

  logic [IDX_W-1:0] load_idx_reg;
  logic [IDX_W-1:0] row_idx_reg;
  logic [CNT_W-1:0] acc_reg;
  logic [7:0]       pass_cnt_reg;
  logic             mode_reg;
  logic             removed_any_reg;
  logic [WIDTH-1:0] prev_row_reg;   // pre-pass copy of row r-1
  logic             finished_reg;
  logic [CNT_W-1:0] result_reg;
  logic [7:0]       passes_reg;

  logic             is_last;
  logic [IDX_W-1:0] next_idx;
  logic [WIDTH-1:0] cur_row;
  logic [WIDTH-1:0] next_row;
  logic [WIDTH+1:0] prev_pad, cur_pad, next_pad;
  logic [WIDTH-1:0] acc_mask;
  logic [RC_W-1:0]  row_cnt;
  logic             pass_removed_any;

  assign is_last  = (row_idx_reg == LAST_ROW);
  assign next_idx = is_last ? '0 : row_idx_reg + IDX_W'(1);
  assign cur_row  = grid_mem[row_idx_reg];
  assign next_row = is_last ? '0 : grid_mem[next_idx];

  // Zero padding at both ends makes out-of-grid columns count as empty.
  assign prev_pad = {1'b0, prev_row_reg, 1'b0};
  assign cur_pad  = {1'b0, cur_row, 1'b0};
  assign next_pad = {1'b0, next_row, 1'b0};

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      logic [3:0] nbr;
      assign nbr = 4'(prev_pad[gi]) + 4'(prev_pad[gi+1]) + 4'(prev_pad[gi+2])
                 + 4'(cur_pad[gi])                        + 4'(cur_pad[gi+2])
                 + 4'(next_pad[gi]) + 4'(next_pad[gi+1]) + 4'(next_pad[gi+2]);
      assign acc_mask[gi] = cur_row[gi] && (nbr < 4'(THR_C));
    end
  endgenerate

  // Population count of accessible cells in the current row.
  always_comb begin
    row_cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row_cnt = row_cnt + RC_W'(acc_mask[i]);
    end
  end

  assign pass_removed_any = removed_any_reg || (row_cnt != '0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic: a pass ends on the last row; mode 1 repeats until a pass removes nothing.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = PROCESS;
      PROCESS: if (is_last && (!mode_reg || !pass_removed_any)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers: load pointer, row walker, accumulator, pass counter, results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_idx_reg    <= '0;
      row_idx_reg     <= '0;
      acc_reg         <= '0;
      pass_cnt_reg    <= '0;
      mode_reg        <= 1'b0;
      removed_any_reg <= 1'b0;
      prev_row_reg    <= '0;
      finished_reg    <= 1'b0;
      result_reg      <= '0;
      passes_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.load_valid) begin
            load_idx_reg <= (load_idx_reg == LAST_ROW) ? '0 : load_idx_reg + IDX_W'(1);
          end
          if (bus.start) begin
            mode_reg        <= bus.mode;
            row_idx_reg     <= '0;
            acc_reg         <= '0;
            pass_cnt_reg    <= '0;
            removed_any_reg <= 1'b0;
            prev_row_reg    <= '0;
            finished_reg    <= 1'b0;
          end
        end
        PROCESS: begin
          acc_reg <= acc_reg + CNT_W'(row_cnt);
          if (is_last) begin
            if (pass_cnt_reg != 8'hFF) pass_cnt_reg <= pass_cnt_reg + 8'd1;
            row_idx_reg     <= '0;
            prev_row_reg    <= '0;
            removed_any_reg <= 1'b0;
          end else begin
            row_idx_reg     <= row_idx_reg + IDX_W'(1);
            prev_row_reg    <= cur_row;
            removed_any_reg <= pass_removed_any;
          end
        end
        DONE: begin
          result_reg   <= acc_reg;
          passes_reg   <= pass_cnt_reg;
          finished_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Grid storage: row loads in IDLE, removal of accessible cells during mode-1 passes.
  always_ff @(posedge clk) begin
    if (state_reg == IDLE && bus.load_valid) begin
      grid_mem[load_idx_reg] <= bus.load_row;
    end else if (state_reg == PROCESS && mode_reg) begin
      grid_mem[row_idx_reg] <= cur_row & ~acc_mask;
    end
  end

  assign bus.load_ready = (state_reg == IDLE);
  assign bus.busy       = (state_reg == PROCESS);
  assign bus.finished   = finished_reg;
  assign bus.result     = result_reg;
  assign bus.passes     = passes_reg;

endmodule

// File: tb/tb_printing_grid_engine.sv
// Scoreboard bench for printing_grid_engine: three instances (10x10, 3x3,
// 140x140) share one stimulus bus; a monitor checks each completion.
module tb_printing_grid_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [1:0]   sel = 2'd0;
  logic         lv = 1'b0, st = 1'b0, md = 1'b0;
  logic [139:0] row_bus = '0;

  printing_grid_engine_if #(.WIDTH(10),  .CNT_W(15)) if_a();
  printing_grid_engine_if #(.WIDTH(3),   .CNT_W(15)) if_b();
  printing_grid_engine_if #(.WIDTH(140), .CNT_W(15)) if_c();

  assign if_a.load_valid = lv && (sel == 2'd0);
  assign if_b.load_valid = lv && (sel == 2'd1);
  assign if_c.load_valid = lv && (sel == 2'd2);
  assign if_a.start = st && (sel == 2'd0);
  assign if_b.start = st && (sel == 2'd1);
  assign if_c.start = st && (sel == 2'd2);
  assign if_a.mode = md;
  assign if_b.mode = md;
  assign if_c.mode = md;
  assign if_a.load_row = row_bus[9:0];
  assign if_b.load_row = row_bus[2:0];
  assign if_c.load_row = row_bus;

  printing_grid_engine #(.WIDTH(10), .HEIGHT(10)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  printing_grid_engine #(.WIDTH(3),  .HEIGHT(3))  dut_b (.clk(clk), .rst(rst), .bus(if_b));
  printing_grid_engine #(.WIDTH(140), .HEIGHT(140), .THRESHOLD(4), .CNT_W(15))
    dut_c (.clk(clk), .rst(rst), .bus(if_c));

  logic [2:0]  fin;
  logic [14:0] res_v [3];
  logic [7:0]  pas_v [3];
  assign fin = {if_c.finished, if_b.finished, if_a.finished};
  assign res_v[0] = if_a.result;
  assign res_v[1] = if_b.result;
  assign res_v[2] = if_c.result;
  assign pas_v[0] = if_a.passes;
  assign pas_v[1] = if_b.passes;
  assign pas_v[2] = if_c.passes;

  typedef struct {
    int id;
    int tag;
    int res;
    int pas;
    int t0;
    int lat;
  } sb_t;
  sb_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every rising finished pops one expected completion.
  logic [2:0] fin_prev = 3'b000;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (fin[k] && !fin_prev[k]) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_finished dut%0d: got result %0d, expected no completion", k, res_v[k]);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk($sformatf("run%0d_dut", e.tag), k, e.id);
          chk($sformatf("run%0d_result", e.tag), int'(res_v[k]), e.res);
          chk($sformatf("run%0d_passes", e.tag), int'(pas_v[k]), e.pas);
          chk($sformatf("run%0d_latency", e.tag), cyc - e.t0, e.lat);
          $display("[TB] run%0d dut%0d result=%0d passes=%0d latency=%0d", e.tag, k, res_v[k], pas_v[k], cyc - e.t0);
        end
      end
    end
    fin_prev = fin;
  end

  string aoc [10] = '{
    "..@@.@@@@.",
    "@@@.@.@.@@",
    "@@@@@.@.@@",
    "@.@@@@..@.",
    "@@.@@@@.@@",
    ".@@@@@@@.@",
    ".@.@.@.@@@",
    "@.@@@.@@@@",
    ".@@@@@@@@.",
    "@.@.@@@.@."
  };

  function automatic logic [139:0] aoc_row(input int r);
    string s;
    logic [139:0] v;
    s = aoc[r];
    v = '0;
    for (int j = 0; j < 10; j++) if (s[j] == "@") v[j] = 1'b1;
    return v;
  endfunction

  function automatic logic [139:0] ones(input int w);
    logic [139:0] v;
    v = '0;
    for (int j = 0; j < w; j++) v[j] = 1'b1;
    return v;
  endfunction

  task automatic load(input int s, input logic [139:0] r);
    @(negedge clk);
    sel = 2'(s);
    lv = 1'b1;
    row_bus = r;
    @(posedge clk);
    #1 lv = 1'b0;
  endtask

  task automatic go(input int s, input logic m, input bit with_row, input logic [139:0] r,
                    input bit skip_sync, input bit expect_fin,
                    input int tag, input int eres, input int epas, input int elat);
    if (!skip_sync) @(negedge clk);
    sel = 2'(s);
    st = 1'b1;
    md = m;
    lv = with_row;
    row_bus = r;
    @(posedge clk);
    #1;
    st = 1'b0;
    lv = 1'b0;
    if (expect_fin) sb.push_back('{s, tag, eres, epas, cyc, elat});
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: %0d completions pending after %0d cycles, expected 0", sb.size(), bound);
      sb.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset is asynchronous: outputs must be cleared before any clock edge.
    #2;
    chk("rst_finished", int'(fin), 0);
    chk("rst_result_a", int'(if_a.result), 0);
    chk("rst_passes_a", int'(if_a.passes), 0);
    chk("rst_busy_a", int'(if_a.busy), 0);
    chk("rst_ready_a", int'(if_a.load_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // AoC example, mode 0, with ignored load pulses during PROCESS.
    for (int r = 0; r < 10; r++) load(0, aoc_row(r));
    go(0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1, 13, 1, 11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("process_ready_a", int'(if_a.load_ready), 0);
      chk("process_busy_a", int'(if_a.busy), 1);
      lv = 1'b1;
      row_bus = ones(140);
      @(posedge clk);
      #1 lv = 1'b0;
    end
    wait_done(100);

    // Rerun mode 0: grid unchanged.
    go(0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 2, 13, 1, 11);
    wait_done(100);

    // Twelve rows into a 10-row grid: last two overwrite rows 0 and 1.
    load(0, ones(140));
    load(0, ones(140));
    for (int r = 2; r < 10; r++) load(0, aoc_row(r));
    load(0, aoc_row(0));
    load(0, aoc_row(1));
    go(0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 3, 43, 10, 101);
    wait_done(300);

    // Reload (load pointer sits at 2), start mode 0, reset during row 5.
    for (int r = 2; r < 10; r++) load(0, aoc_row(r));
    load(0, aoc_row(0));
    load(0, aoc_row(1));
    go(0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 4, 0, 0, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_busy_before", int'(if_a.busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", int'(if_a.busy), 0);
    chk("abort_finished", int'(if_a.finished), 0);
    chk("abort_result", int'(if_a.result), 0);
    chk("abort_passes", int'(if_a.passes), 0);
    chk("abort_ready", int'(if_a.load_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("abort_no_finish", int'(if_a.finished), 0);
    for (int r = 0; r < 10; r++) load(0, aoc_row(r));
    go(0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 5, 13, 1, 11);
    wait_done(100);

    // 3x3 all ones: last row loaded in the same cycle as start.
    load(1, ones(3));
    load(1, ones(3));
    go(1, 1'b0, 1'b1, ones(3), 1'b0, 1'b1, 6, 4, 1, 4);
    wait_done(50);
    for (int r = 0; r < 3; r++) load(1, ones(3));
    go(1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 7, 9, 4, 13);
    wait_done(50);
    // Grid now empty.
    go(1, 1'b1, 1'b0, '0, 1'b0, 1'b1, 8, 0, 1, 4);
    wait_done(50);
    go(1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 9, 0, 1, 4);
    wait_done(50);
    repeat (4) @(negedge clk);
    chk("hold_finished_b", int'(if_b.finished), 1);
    chk("hold_passes_b", int'(if_b.passes), 1);

    // Default size, all ones, back-to-back start the cycle after finished.
    for (int r = 0; r < 140; r++) load(2, ones(140));
    go(2, 1'b0, 1'b0, '0, 1'b0, 1'b1, 10, 4, 1, 141);
    begin
      int n;
      n = 0;
      while (!if_c.finished && n < 400) begin
        @(negedge clk);
        n++;
      end
      chk("c_first_finished", int'(if_c.finished), 1);
    end
    go(2, 1'b0, 1'b0, '0, 1'b1, 1'b1, 11, 4, 1, 141);
    chk("c_b2b_cleared", int'(if_c.finished), 0);
    wait_done(400);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/printing_grid_engine.md
PRINTING_GRID_ENGINE -- requirements
Module: printing_grid_engine

Interface
REQ-001 Parameter WIDTH, default 140, grid columns (>=2).
REQ-002 Parameter HEIGHT, default 140, grid rows (>=2, <=255).
REQ-003 Parameter THRESHOLD, default 4; occupied cell accessible when occupied-neighbour count < THRESHOLD.
REQ-004 Parameter CNT_W, default 15, result width; SHALL satisfy 2^CNT_W > WIDTH*HEIGHT.
REQ-005 clk  input  1  clock, rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 load_valid  input  1  load_row carries a grid row.
REQ-008 load_row  input  WIDTH  row bits, bit j = column j, 1 = occupied.
REQ-009 load_ready  output  1  high exactly when state is IDLE.
REQ-010 start  input  1  begin evaluation, sampled in IDLE only.
REQ-011 mode  input  1  0 = single count pass, 1 = iterative removal; sampled with start.
REQ-012 busy  output  1  high in PROCESS.
REQ-013 finished  output  1  result valid.
REQ-014 result  output  CNT_W  accessible (mode 0) or total removed (mode 1) count.
REQ-015 passes  output  8  completed passes of last run.

Function
REQ-016 States IDLE, PROCESS, DONE; internal HEIGHT x WIDTH grid storage, no file initialisation.
REQ-017 IDLE: each cycle with load_valid high writes load_row to row load_idx, load_idx increments, wraps HEIGHT-1 -> 0.
REQ-018 IDLE with start high: mode latched, row_idx, accumulator, pass counter cleared, finished cleared, -> PROCESS; a simultaneous load_valid row is still written that cycle.
REQ-019 start outside IDLE ignored; load_valid outside IDLE ignored.
REQ-020 PROCESS: one row per cycle, row_idx 0..HEIGHT-1; neighbours = 8 surrounding cells, out-of-grid cells count as 0.
REQ-021 Per row: accumulator += number of occupied cells with neighbour count < THRESHOLD.
REQ-022 Mode 1: accessible cells of row r cleared in storage at end of its cycle; evaluation uses pre-pass values of rows r-1, r, r+1 (pass-synchronous semantics; copy of original row r-1 retained).
REQ-023 Row HEIGHT-1 cycle: pass counter increments (saturating at 255); mode 0 -> DONE; mode 1 -> DONE if that pass removed 0 cells, else row_idx <- 0 and next pass starts the following cycle, no bubble.
REQ-024 DONE (one cycle): result <= accumulator, passes <= pass counter, finished <= 1, -> IDLE.
REQ-025 finished, result, passes hold until the next accepted start; finished clears on that start.
REQ-026 Latency mode 0: start sampled at edge T; finished high after edge T+HEIGHT+1.
REQ-027 Latency mode 1 with P passes: finished high after edge T+P*HEIGHT+1.
REQ-028 Mode 0 leaves grid unchanged (rerun gives same result); mode 1 leaves grid at fixed point, reload required to rerun.
REQ-029 Empty grid: mode 0 result 0, passes 1; mode 1 result 0, passes 1.

Reset
REQ-030 rst asserted: state IDLE, finished 0, result 0, passes 0, busy 0, load_idx 0, row_idx 0, accumulator 0, immediately and regardless of clk.
REQ-031 Grid storage not reset; contents after rst undefined for checking, reload required.
REQ-032 rst mid-PROCESS aborts run; no finished pulse for aborted run.

Verification
REQ-033 AoC 10x10 example loaded (WIDTH=HEIGHT=10), start mode 0 -> result 13, passes 1, finished after 11 cycles.
REQ-034 Same grid reloaded, start mode 1 -> result 43, finished after passes*10+1 cycles.
REQ-035 3x3 all ones, mode 0 -> result 4; reload, mode 1 -> result 9, passes 4 (4 corners, 4 edges, centre, zero pass).
REQ-036 Load 12 rows into HEIGHT=10 -> rows 10,11 overwrite rows 0,1; load_ready 0 throughout PROCESS, load_valid pulses there do not alter grid.
REQ-037 rst pulse at row 5 of mode-0 run -> all outputs 0 asynchronously; reload, start -> correct result, no stale finished.
REQ-038 Default 140x140, mode 0, back-to-back start on the cycle after finished -> second result equals first.
